ce_phase_gen: RTL and testbench
===============================

# ce_phase_gen

Parametrised clock-enable phase generator for the Spectrum core. It runs on the PLL master clock and produces a ladder of single-cycle rising and falling enable pulses for binary-divided clock domains: video pixel, ULA and CPU. It also produces a CPU enable pair on top of that ladder, with glitch-free turbo switching and a contention stall that stretches the low phase of the CPU clock. It sits directly after PLL selection and feeds the ULA, CPU and audio blocks.

## Interface
- BASE, 2: log2 of the base enable period in master clocks. `base_ce` fires every 2^BASE clocks.
- STAGES, 3: number of divided stages. Stage k has a period of 2^(BASE+k+1) clocks. Valid range 1..8.
- clock  in  1  master clock. All logic is clocked on its falling edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  count enable, driven by the PLL-locked indication. When low, everything freezes.
- turbo  in  2  CPU speed select: 0 = x1, 1 = x2, 2 = x4, 3 = x8.
- stall  in  1  contention request. Blocks CPU rising enables only.
- base_ce  out  1  base-rate enable pulse.
- pe  out  STAGES  per-stage rising-phase enable pulses.
- ne  out  STAGES  per-stage falling-phase enable pulses.
- cpu_pe  out  1  CPU clock rising enable.
- cpu_ne  out  1  CPU clock falling enable.
- phase  out  CW  current counter value, where CW = BASE+STAGES.

## Operation
- Counter `phase` is CW bits wide. It increments by 1 on each enabled cycle and wraps from 2^CW-1 to 0 with no special case.
- Pulse slots are decoded from the pre-increment `phase` value and registered:
  - base_ce: low BASE bits are 0.
  - ne[k]: low BASE+k+1 bits are 0.
  - pe[k]: low BASE+k bits are 0 and bit BASE+k is 1.
- CPU stage selection:
  - Selected stage s = STAGES-1-active_turbo, clamped to 0.
  - active_turbo is loaded from `turbo` only in the ne[STAGES-1] slot (`phase` == 0). Every stage's ne coincides in that slot, so a speed change never produces a short CPU phase.
- cpu_level state register (0 = CPU clock low, 1 = high):
  - pe[s] slot with cpu_level=0 and stall=0: assert cpu_pe and set cpu_level=1.
  - pe[s] slot with stall=1: no cpu_pe, cpu_level stays 0. The next opportunity is the following pe[s] slot.
  - ne[s] slot with cpu_level=1: assert cpu_ne and clear cpu_level. stall has no effect on ne.
  - ne[s] slot with cpu_level=0: no cpu_ne.
- enable=0:
  - `phase`, cpu_level and active_turbo hold.
  - All pulse outputs are 0 on the following cycle.
  - Counting resumes from the held `phase` when enable returns high.

## Timing
- Reset values: phase=0, cpu_level=0, active_turbo=0, and every pulse output 0.
- Reset has priority over enable. A mid-operation reset takes effect on the next edge.
- Latency: a pulse is visible for exactly 1 cycle, on the cycle after the edge at which `phase` held its slot value.
- First enabled edge after reset (phase=0) raises base_ce, all ne[k], and the registered turbo load on the next output.
- A turbo change mid-period is ignored until `phase` next equals 0. The worst-case delay is 2^CW-1 cycles.
- With stall and a pe[s] slot in the same cycle, stall wins.

## Configuration
- CE_TURBO_EN defined: `turbo` is honoured as described above.
- CE_TURBO_EN undefined:
  - `turbo` is ignored and active_turbo is tied to 0.
  - cpu_pe/cpu_ne always follow stage STAGES-1 (with stall gating).
  - The turbo register and stage-select mux are removed.

## Test plan
All scenarios use the defaults (BASE=2, STAGES=3, CW=5).
- Reset, then enable=1 for 64 cycles, turbo=0, stall=0:
  - base_ce every 4 cycles.
  - ne[0]/ne[1]/ne[2] at phase 0 mod 8/16/32.
  - pe[0] at phase 4, 12, 20, 28.
  - cpu_pe at phase 16, cpu_ne at phase 0 (from the second period onward).
- turbo changed 0 to 2 at phase 5 (CE_TURBO_EN defined):
  - CPU stays on stage 2 until phase 0.
  - CPU then follows stage 0: cpu_pe at 4, 12, 20, 28 and cpu_ne at 0, 8, 16, 24.
- turbo=0, stall held high across phase 16:
  - No cpu_pe in that period.
  - No cpu_ne at the following phase 0.
  - cpu_pe resumes at the next phase 16 with stall low.
- enable dropped at phase 7 for 10 cycles: all pulses are 0, `phase` reads 7 throughout, and counting continues 8, 9, … after release.
- reset asserted with enable=0 at phase 19, cpu_level=1: next cycle phase=0, all outputs 0, cpu_level=0.
- CE_TURBO_EN undefined, turbo=3: cpu_pe/cpu_ne are identical to the turbo=0 run of scenario 1.

Source files
------------

// File: rtl/ce_phase_gen.sv
// Clock-enable phase generator: binary ladder of rising/falling enable pulses
// plus a CPU enable pair with turbo selection (CE_TURBO_EN) and contention stall.
module ce_phase_gen #(
  parameter int BASE   = 2,
  parameter int STAGES = 3,
  localparam int CW    = BASE + STAGES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        turbo,
  input  logic              stall,
  output logic              base_ce,
  output logic [STAGES-1:0] pe,
  output logic [STAGES-1:0] ne,
  output logic              cpu_pe,
  output logic              cpu_ne,
  output logic [CW-1:0]     phase
);

  // True when the low n bits of value are all zero (n == 0 is always true).
  function automatic logic low_zero(input logic [CW-1:0] value, input int n);
    return (value & ~({CW{1'b1}} << n)) == '0;
  endfunction

  logic              base_slot;
  logic [STAGES-1:0] pe_slot;
  logic [STAGES-1:0] ne_slot;
  logic [STAGES-1:0] stage_mask;
  logic              sel_pe;
  logic              sel_ne;
  logic              cpu_rise;
  logic              cpu_fall;
  logic              cpu_level;
  int                sel;

  assign base_slot = low_zero(phase, BASE);

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    assign ne_slot[k]    = low_zero(phase, BASE + k + 1);
    assign pe_slot[k]    = low_zero(phase, BASE + k) && phase[BASE + k];
    assign stage_mask[k] = (sel == k);
  end

`ifdef CE_TURBO_EN
  logic [1:0] active_turbo;

  // Loaded only where every stage's falling slot coincides, so a speed change
  // can never shorten a CPU clock phase.
  always_ff @(negedge clock) begin
    if (!reset)
      active_turbo <= 2'd0;
    else if (enable && ne_slot[STAGES-1])
      active_turbo <= turbo;
  end

  always_comb begin
    sel = STAGES - 1 - int'(active_turbo);
    if (sel < 0)
      sel = 0;
  end
`else
  logic [1:0] unused_turbo;

  assign unused_turbo = turbo;

  always_comb begin
    sel = STAGES - 1;
  end
`endif

  // NOTE: combinational blocks assign every output a default before any
  // condition, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel_pe   = |(pe_slot & stage_mask);
    sel_ne   = |(ne_slot & stage_mask);
    cpu_rise = 1'b0;
    cpu_fall = 1'b0;
    if (sel_pe && !cpu_level && !stall)
      cpu_rise = 1'b1;
    if (sel_ne && cpu_level)
      cpu_fall = 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(negedge clock) begin
    if (!reset) begin
      phase     <= '0;
      cpu_level <= 1'b0;
      base_ce   <= 1'b0;
      pe        <= '0;
      ne        <= '0;
      cpu_pe    <= 1'b0;
      cpu_ne    <= 1'b0;
    end else if (enable) begin
      phase   <= phase + CW'(1);
      base_ce <= base_slot;
      pe      <= pe_slot;
      ne      <= ne_slot;
      cpu_pe  <= cpu_rise;
      cpu_ne  <= cpu_fall;
      if (cpu_rise)
        cpu_level <= 1'b1;
      else if (cpu_fall)
        cpu_level <= 1'b0;
    end else begin
      // Counter and CPU level hold; pulses must not repeat while frozen.
      base_ce <= 1'b0;
      pe      <= '0;
      ne      <= '0;
      cpu_pe  <= 1'b0;
      cpu_ne  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ce_phase_gen.sv
// Self-checking bench for ce_phase_gen: a behavioural model pushes expected
// outputs per edge into a scoreboard queue; directed counts check the ladder.
module tb_ce_phase_gen;

  localparam int BASE   = 2;
  localparam int STAGES = 3;
  localparam int CW     = BASE + STAGES;

  typedef struct packed {
    logic              base;
    logic [STAGES-1:0] pe;
    logic [STAGES-1:0] ne;
    logic              cpu_pe;
    logic              cpu_ne;
    logic [CW-1:0]     phase;
  } obs_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        turbo;
  logic              stall;
  logic              base_ce;
  logic [STAGES-1:0] pe;
  logic [STAGES-1:0] ne;
  logic              cpu_pe;
  logic              cpu_ne;
  logic [CW-1:0]     phase;

  ce_phase_gen #(.BASE(BASE), .STAGES(STAGES)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .turbo  (turbo),
    .stall  (stall),
    .base_ce(base_ce),
    .pe     (pe),
    .ne     (ne),
    .cpu_pe (cpu_pe),
    .cpu_ne (cpu_ne),
    .phase  (phase)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t last;
  int   m_phase = 0;
  int   m_turbo = 0;
  bit   m_level = 1'b0;
  int   n_base, n_pe0, n_ne2, n_cpu_pe, n_cpu_ne;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one falling edge, expressed with modulo arithmetic.
  task automatic model_edge(output obs_t e);
    int per;
    int s;
    e = '0;
    if (!reset) begin
      m_phase = 0;
      m_level = 1'b0;
      m_turbo = 0;
    end else if (!enable) begin
      e.phase = CW'(m_phase);
    end else begin
      e.base = (m_phase % (1 << BASE)) == 0;
      for (int k = 0; k < STAGES; k++) begin
        per     = 1 << (BASE + k + 1);
        e.ne[k] = (m_phase % per) == 0;
        e.pe[k] = (m_phase % per) == per / 2;
      end
`ifdef CE_TURBO_EN
      s = STAGES - 1 - m_turbo;
      if (s < 0) s = 0;
`else
      s = STAGES - 1;
`endif
      e.cpu_pe = e.pe[s] && !m_level && !stall;
      e.cpu_ne = e.ne[s] && m_level;
      if (e.cpu_pe) m_level = 1'b1;
      else if (e.cpu_ne) m_level = 1'b0;
`ifdef CE_TURBO_EN
      if (m_phase == 0) m_turbo = int'(turbo);
`endif
      m_phase = (m_phase + 1) % (1 << CW);
      e.phase = CW'(m_phase);
    end
  endtask

  task automatic clear_counts();
    n_base = 0; n_pe0 = 0; n_ne2 = 0; n_cpu_pe = 0; n_cpu_ne = 0;
  endtask

  // Drive inputs away from the falling edge, push the expectation, let the
  // edge happen, then pop and compare on the following rising edge.
  task automatic step(input logic rst_i, input logic en_i,
                      input logic [1:0] trb_i, input logic stl_i);
    obs_t e;
    obs_t x;
    reset  = rst_i;
    enable = en_i;
    turbo  = trb_i;
    stall  = stl_i;
    model_edge(e);
    exp_q.push_back(e);
    @(negedge clock);
    @(posedge clock);
    last = '{base: base_ce, pe: pe, ne: ne, cpu_pe: cpu_pe, cpu_ne: cpu_ne, phase: phase};
    x = exp_q.pop_front();
    check("pulses", 32'(last[13:CW]), 32'(x[13:CW]));
    check("phase", 32'(last.phase), 32'(x.phase));
    n_base   += int'(last.base);
    n_pe0    += int'(last.pe[0]);
    n_ne2    += int'(last.ne[STAGES-1]);
    n_cpu_pe += int'(last.cpu_pe);
    n_cpu_ne += int'(last.cpu_ne);
  endtask

  task automatic run(input int n, input logic [1:0] trb_i, input logic stl_i);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, trb_i, stl_i);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; turbo = 2'd0; stall = 1'b0;

    // Reset, including reset winning over enable.
    step(1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    check("reset_outputs", 32'(last), 32'd0);

    // Free run, two full periods at x1.
    clear_counts();
    run(64, 2'd0, 1'b0);
    check("s1_base_ce_count", n_base, 16);
    check("s1_pe0_count", n_pe0, 8);
    check("s1_ne2_count", n_ne2, 2);
    check("s1_cpu_pe_count", n_cpu_pe, 2);
    check("s1_cpu_ne_count", n_cpu_ne, 1);

    // Turbo request at phase 5; takes effect only from the next phase 0.
    run(5, 2'd0, 1'b0);
    check("turbo_req_phase", 32'(last.phase), 32'd5);
    clear_counts();
    run(27, 2'd3 - 2'd1, 1'b0);
    check("turbo_hold_cpu_pe", n_cpu_pe, 1);
    clear_counts();
`ifdef CE_TURBO_EN
    run(32, 2'd2, 1'b0);
    check("turbo_fast_cpu_pe", n_cpu_pe, 4);
    check("turbo_fast_cpu_ne", n_cpu_ne, 4);
`else
    run(32, 2'd3, 1'b0);
    check("turbo_off_cpu_pe", n_cpu_pe, 1);
    check("turbo_off_cpu_ne", n_cpu_ne, 1);
`endif
    run(32, 2'd0, 1'b0);

    // Stall held across phase 16 blocks that period's rise and next fall.
    run(16, 2'd0, 1'b0);
    clear_counts();
    run(2, 2'd0, 1'b1);
    run(14, 2'd0, 1'b0);
    check("stall_cpu_pe", n_cpu_pe, 0);
    clear_counts();
    run(32, 2'd0, 1'b0);
    check("stall_next_cpu_ne", n_cpu_ne, 0);
    check("stall_resume_cpu_pe", n_cpu_pe, 1);

    // Enable dropped at phase 7 for 10 cycles.
    run(7, 2'd0, 1'b0);
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0);
      check("hold_phase", 32'(last.phase), 32'd7);
    end
    check("hold_no_pulses", n_base + n_pe0 + n_ne2 + n_cpu_pe + n_cpu_ne, 0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    check("resume_phase_8", 32'(last.phase), 32'd8);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    check("resume_phase_9", 32'(last.phase), 32'd9);

    // Reset at phase 19 with the CPU clock high and enable low.
    run(10, 2'd0, 1'b0);
    check("pre_reset_phase", 32'(last.phase), 32'd19);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("mid_reset_outputs", 32'(last), 32'd0);
    step(1'b1, 1'b1, 2'd0, 1'b0);
    check("post_reset_no_cpu_ne", 32'(last.cpu_ne), 32'd0);
    check("post_reset_ne2", 32'(last.ne[STAGES-1]), 32'd1);
    clear_counts();
    run(17, 2'd0, 1'b0);
    check("post_reset_cpu_pe", n_cpu_pe, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
